// File: rtl/icache_port_arbiter_if.sv
// Bundle of the fetch-side and cache-side signals of the I-cache port
// arbiter. The arbiter connects through the slave modport; the fetch units
// and the cache model connect through the master modport.
//
// Handshakes:
//   req_valid[i] is raised by requester i and held with a stable
//   req_addr slice until the one-cycle req_ack[i] pulse. cache_req is held
//   with a stable cache_addr until a cycle with cache_ready=1, which is the
//   transfer cycle. cache_resp_valid is a one-cycle pulse that carries
//   cache_resp_data. resp_valid is a one-cycle, one-hot-or-zero pulse that
//   carries resp_data.

`ifndef INSTRUCTION_WIDTH
`define INSTRUCTION_WIDTH 32
`endif

interface icache_port_arbiter_if #(
    parameter int NUM_REQ = 2
);
    localparam int W = `INSTRUCTION_WIDTH;

    // fetch side
    logic [NUM_REQ-1:0]   req_valid;
    logic [NUM_REQ*W-1:0] req_addr;
    logic [NUM_REQ-1:0]   req_flush;
    logic [NUM_REQ-1:0]   req_ack;
    logic [NUM_REQ-1:0]   resp_valid;
    logic [W-1:0]         resp_data;

    // cache side
    logic                 cache_req;
    logic [W-1:0]         cache_addr;
    logic                 cache_ready;
    logic                 cache_resp_valid;
    logic [W-1:0]         cache_resp_data;

    modport slave (
        input  req_valid, req_addr, req_flush,
        input  cache_ready, cache_resp_valid, cache_resp_data,
        output req_ack, resp_valid, resp_data,
        output cache_req, cache_addr
    );

    modport master (
        output req_valid, req_addr, req_flush,
        output cache_ready, cache_resp_valid, cache_resp_data,
        input  req_ack, resp_valid, resp_data,
        input  cache_req, cache_addr
    );
endinterface

// File: rtl/icache_port_arbiter.sv
// Round-robin arbiter sharing one instruction-cache read port between
// NUM_REQ fetch requesters. One cache transaction is in flight at a time.
// The granted requester may flush its fetch; the cache transaction still
// completes, but the returned instruction is discarded.
//
// dbg_state encoding: 0 = IDLE, 1 = ISSUE (cache_req up), 2 = WAIT (response
// pending). dbg_rr_ptr is the requester index the next search starts from.

`ifndef INSTRUCTION_WIDTH
`define INSTRUCTION_WIDTH 32
`endif

module icache_port_arbiter #(
    parameter int NUM_REQ = 2,
    parameter int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    icache_port_arbiter_if.slave bus,
    output logic [1:0]           dbg_state,
    output logic [IDX_W-1:0]     dbg_rr_ptr
);
    localparam int W = `INSTRUCTION_WIDTH;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } state_t;

    state_t             state;
    logic [IDX_W-1:0]   rr_ptr;
    logic [IDX_W-1:0]   grant_idx;
    logic               drop;

    logic               pick_found;
    logic [IDX_W-1:0]   pick_idx;
    logic [NUM_REQ-1:0] pick_onehot;
    logic [W-1:0]       pick_addr;
    logic [NUM_REQ-1:0] grant_onehot;
    logic               flush_g;
    logic               resp_take;
    logic               deliver;
    logic [IDX_W-1:0]   next_ptr;

    assign dbg_state  = state;
    assign dbg_rr_ptr = rr_ptr;

    // Round-robin search: first requesting index at or after rr_ptr, wrapping.
    always_comb begin
        int j;
        logic [IDX_W-1:0] cand;
        j          = 0;
        cand       = '0;
        pick_found = 1'b0;
        pick_idx   = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            j = int'(rr_ptr) + k;
            if (j >= NUM_REQ) begin
                j = j - NUM_REQ;
            end
            cand = IDX_W'(j);
            if (!pick_found && bus.req_valid[cand]) begin
                pick_found = 1'b1;
                pick_idx   = cand;
            end
        end
    end

    // Decode the picked index into its ack bit and address slice, and the
    // granted index into its response bit.
    always_comb begin
        pick_onehot  = '0;
        grant_onehot = '0;
        pick_addr    = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (IDX_W'(i) == pick_idx) begin
                pick_onehot[i] = 1'b1;
                pick_addr      = bus.req_addr[i*W +: W];
            end
            if (IDX_W'(i) == grant_idx) begin
                grant_onehot[i] = 1'b1;
            end
        end
    end

    // Flush only matters for the owner of the in-flight transaction.
    assign flush_g = bus.req_flush[grant_idx];

    // A response counts in WAIT, or in ISSUE when it arrives together with
    // the request being accepted; otherwise it is ignored.
    assign resp_take = bus.cache_resp_valid &&
                       ((state == WAIT) || ((state == ISSUE) && bus.cache_ready));

    // A flush seen in the completion cycle itself also suppresses the pulse.
    assign deliver = resp_take && !drop && !flush_g;

    assign next_ptr = (grant_idx == IDX_W'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;

    // Arbitration FSM with all outputs registered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= IDLE;
            rr_ptr         <= '0;
            grant_idx      <= '0;
            drop           <= 1'b0;
            bus.req_ack    <= '0;
            bus.resp_valid <= '0;
            bus.resp_data  <= '0;
            bus.cache_req  <= 1'b0;
            bus.cache_addr <= '0;
        end else begin
            bus.req_ack    <= '0;
            bus.resp_valid <= '0;
            case (state)
                IDLE: begin
                    if (pick_found) begin
                        grant_idx      <= pick_idx;
                        bus.cache_addr <= pick_addr;
                        bus.cache_req  <= 1'b1;
                        bus.req_ack    <= pick_onehot;
                        drop           <= 1'b0;
                        state          <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (bus.cache_ready) begin
                        bus.cache_req <= 1'b0;
                        if (resp_take) begin
                            if (deliver) begin
                                bus.resp_valid <= grant_onehot;
                                bus.resp_data  <= bus.cache_resp_data;
                            end
                            drop   <= 1'b0;
                            rr_ptr <= next_ptr;
                            state  <= IDLE;
                        end else begin
                            drop  <= drop | flush_g;
                            state <= WAIT;
                        end
                    end else begin
                        drop <= drop | flush_g;
                    end
                end
                WAIT: begin
                    if (resp_take) begin
                        if (deliver) begin
                            bus.resp_valid <= grant_onehot;
                            bus.resp_data  <= bus.cache_resp_data;
                        end
                        drop   <= 1'b0;
                        rr_ptr <= next_ptr;
                        state  <= IDLE;
                    end else begin
                        drop <= drop | flush_g;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_icache_port_arbiter.sv
// Bench for icache_port_arbiter: directed scenarios followed by random
// traffic, all checked cycle by cycle against a transaction-level model.

`ifndef INSTRUCTION_WIDTH
`define INSTRUCTION_WIDTH 32
`endif

module tb_icache_port_arbiter;
    localparam int N  = 2;
    localparam int W  = `INSTRUCTION_WIDTH;
    localparam int IW = $clog2(N);

    // ---------------- clock / reset ----------------
    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [1:0]    dbg_state;
    logic [IW-1:0] dbg_rr_ptr;

    icache_port_arbiter_if #(.NUM_REQ(N)) bus ();

    icache_port_arbiter #(.NUM_REQ(N)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .bus        (bus),
        .dbg_state  (dbg_state),
        .dbg_rr_ptr (dbg_rr_ptr)
    );

    // ---------------- scoreboard / model state ----------------
    int n_vec = 0;
    int n_err = 0;

    logic [W-1:0] addr [N];
    logic [N-1:0] pend;
    logic [N-1:0] flm;

    // transaction-level model of the arbiter
    bit           m_busy;
    bit           m_issued;
    bit           m_drop;
    int           m_owner;
    int           m_ptr;
    logic [N-1:0] exp_ack;
    logic [N-1:0] exp_resp;
    logic         exp_creq;
    logic [W-1:0] exp_caddr;
    logic [W-1:0] exp_hold;
    logic [W-1:0] exp_q[$];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic pack_addr();
        for (int i = 0; i < N; i++) begin
            bus.req_addr[i*W +: W] = addr[i];
        end
    endtask

    task automatic drive(input logic [N-1:0] rv, input logic [N-1:0] fl,
                         input logic rdy, input logic rvld, input logic [W-1:0] d);
        pack_addr();
        bus.req_valid        = rv;
        bus.req_flush        = fl;
        bus.cache_ready      = rdy;
        bus.cache_resp_valid = rvld;
        bus.cache_resp_data  = d;
    endtask

    task automatic model_reset();
        m_busy    = 0;
        m_issued  = 0;
        m_drop    = 0;
        m_owner   = 0;
        m_ptr     = 0;
        exp_ack   = '0;
        exp_resp  = '0;
        exp_creq  = 1'b0;
        exp_caddr = '0;
        exp_hold  = '0;
        exp_q.delete();
    endtask

    // Predict what the next clock edge produces from the current inputs.
    task automatic model_edge();
        bit fl;
        bit accepted_now;
        bit resp_counts;
        exp_ack  = '0;
        exp_resp = '0;
        if (!m_busy) begin
            for (int k = 0; k < N; k++) begin
                int j;
                j = (m_ptr + k) % N;
                if (bus.req_valid[j]) begin
                    m_owner    = j;
                    m_busy     = 1;
                    m_issued   = 0;
                    m_drop     = 0;
                    exp_ack[j] = 1'b1;
                    exp_creq   = 1'b1;
                    exp_caddr  = addr[j];
                    break;
                end
            end
        end else begin
            fl           = bus.req_flush[m_owner];
            accepted_now = !m_issued && bus.cache_ready;
            resp_counts  = bus.cache_resp_valid && (m_issued || accepted_now);
            if (accepted_now) begin
                exp_creq = 1'b0;
                m_issued = 1;
            end
            if (resp_counts) begin
                if (!m_drop && !fl) begin
                    exp_resp[m_owner] = 1'b1;
                    exp_hold          = bus.cache_resp_data;
                    exp_q.push_back(bus.cache_resp_data);
                end
                m_busy = 0;
                m_ptr  = (m_owner + 1) % N;
            end else if (fl) begin
                m_drop = 1;
            end
        end
    endtask

    task automatic compare_outputs();
        check("req_ack", 64'(bus.req_ack), 64'(exp_ack));
        check("resp_valid", 64'(bus.resp_valid), 64'(exp_resp));
        check("cache_req", 64'(bus.cache_req), 64'(exp_creq));
        check("cache_addr", 64'(bus.cache_addr), 64'(exp_caddr));
        if (exp_resp != '0 && exp_q.size() > 0) begin
            check("resp_data", 64'(bus.resp_data), 64'(exp_q.pop_front()));
        end else begin
            check("resp_data_hold", 64'(bus.resp_data), 64'(exp_hold));
        end
        check("rr_ptr", 64'(dbg_rr_ptr), 64'(m_ptr));
        check("idle", 64'(dbg_state == 2'd0), 64'(!m_busy));
    endtask

    // Inputs are already applied at a falling edge; advance one cycle.
    task automatic step();
        model_edge();
        @(posedge clk);
        @(negedge clk);
        compare_outputs();
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("rst_req_ack", 64'(bus.req_ack), 64'd0);
        check("rst_resp_valid", 64'(bus.resp_valid), 64'd0);
        check("rst_cache_req", 64'(bus.cache_req), 64'd0);
        check("rst_cache_addr", 64'(bus.cache_addr), 64'd0);
        check("rst_resp_data", 64'(bus.resp_data), 64'd0);
        check("rst_rr_ptr", 64'(dbg_rr_ptr), 64'd0);
        check("rst_state", 64'(dbg_state), 64'd0);
        model_reset();
        pend = '0;
        drive('0, '0, 1'b0, 1'b0, '0);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        for (int i = 0; i < N; i++) addr[i] = '0;
        pend = '0;
        flm  = '0;
        model_reset();
        drive('0, '0, 1'b0, 1'b0, '0);
        do_reset();

        // single request, cache accepts in one cycle, response two cycles later
        addr[0] = 32'h100;
        drive(2'b01, '0, 1'b0, 1'b0, '0);             step();
        drive('0, '0, 1'b1, 1'b0, '0);                step();
        drive('0, '0, 1'b0, 1'b0, '0);                step();
        drive('0, '0, 1'b0, 1'b1, 32'hDEADBEEF);      step();
        drive('0, '0, 1'b0, 1'b0, '0);                step();

        // contention: both requesting continuously, grants alternate
        addr[0] = 32'hA000;
        addr[1] = 32'hB000;
        for (int t = 0; t < 4; t++) begin
            drive(2'b11, '0, 1'b0, 1'b0, '0);         step();
            drive(2'b11, '0, 1'b1, 1'b0, '0);         step();
            drive(2'b11, '0, 1'b0, 1'b1, 32'(32'h5000 + t)); step();
        end

        // backpressure: cache_ready low five cycles, accepted on the sixth
        addr[1] = 32'h2000;
        drive(2'b10, '0, 1'b0, 1'b0, '0);             step();
        for (int t = 0; t < 5; t++) begin
            drive(2'b11, '0, 1'b0, 1'b0, '0);         step();
        end
        drive(2'b11, '0, 1'b1, 1'b0, '0);             step();
        drive('0, '0, 1'b0, 1'b1, 32'hCAFE0001);      step();

        // flush of the granted requester while waiting: response dropped
        drive(2'b10, '0, 1'b0, 1'b0, '0);             step();
        drive('0, '0, 1'b1, 1'b0, '0);                step();
        drive('0, 2'b10, 1'b0, 1'b0, '0);             step();
        drive('0, '0, 1'b0, 1'b1, 32'hBAD0BAD0);      step();
        drive(2'b01, '0, 1'b0, 1'b0, '0);             step();
        drive('0, 2'b10, 1'b1, 1'b1, 32'h0000_0777);  step();

        // ready and response together in ISSUE, then an immediate regrant
        drive(2'b10, '0, 1'b0, 1'b0, '0);             step();
        drive('0, '0, 1'b1, 1'b1, 32'h1234);          step();
        drive(2'b01, '0, 1'b0, 1'b0, '0);             step();
        drive('0, '0, 1'b1, 1'b1, 32'h4321);          step();

        // reset while waiting, then a clean grant to requester 1
        drive(2'b10, '0, 1'b0, 1'b0, '0);             step();
        drive('0, '0, 1'b1, 1'b0, '0);                step();
        do_reset();
        drive(2'b10, '0, 1'b0, 1'b1, 32'h5A5A5A5A);   step();
        drive('0, '0, 1'b1, 1'b0, '0);                step();
        drive('0, '0, 1'b0, 1'b1, 32'h600D600D);      step();

        // random traffic: requests held until ack, random flushes and cache timing
        for (int c = 0; c < 800; c++) begin
            for (int i = 0; i < N; i++) begin
                if (!pend[i] && $urandom_range(0, 2) == 0) begin
                    pend[i] = 1'b1;
                    addr[i] = $urandom;
                end
            end
            flm = '0;
            for (int i = 0; i < N; i++) begin
                if ($urandom_range(0, 7) == 0) flm[i] = 1'b1;
            end
            drive(pend, flm, ($urandom_range(0, 1) == 1), ($urandom_range(0, 2) == 0), $urandom);
            step();
            for (int i = 0; i < N; i++) begin
                if (exp_ack[i]) pend[i] = 1'b0;
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
